spi_frame_ctrl: RTL

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

---
 rtl/spi_frame_if.sv | 29 ++
 rtl/spi_frame_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_if.sv
// Byte-stream / measurement-buffer bundle for the SPI frame controller.
// master: the side feeding received bytes and consuming the buffer (solver/bench).
// slave:  the frame controller itself.
interface spi_frame_if #(
    parameter int ADDR_W = 6
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              spi_active;
    logic              frame_ack;
    logic              err_clr;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [15:0]       buf_wdata;
    logic              frame_valid;
    logic [ADDR_W:0]   frame_len;
    logic              busy;
    logic [3:0]        err_flags;

    modport master (
        output byte_valid, byte_data, spi_active, frame_ack, err_clr,
        input  buf_we, buf_addr, buf_wdata, frame_valid, frame_len, busy, err_flags
    );

    modport slave (
        input  byte_valid, byte_data, spi_active, frame_ack, err_clr,
        output buf_we, buf_addr, buf_wdata, frame_valid, frame_len, busy, err_flags
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: parses  A5 | N | {hi,lo} x N  byte messages and
// writes the 16-bit samples into a measurement buffer, then holds the
// frame for a downstream solver until acknowledged. Sticky error flags
// record sync, length, abort (chip-select drop) and overrun events.
module spi_frame_ctrl #(
    parameter int MAX_SAMPLES = 64,
    parameter int ADDR_W      = 6
) (
    input logic        clk,
    input logic        rst_n,
    spi_frame_if.slave bus
);

    localparam int         LEN_W     = ADDR_W + 1;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_SAMPLES);

    // Bit positions inside err_flags
    localparam int ERR_SYNC    = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_ABORT   = 2;
    localparam int ERR_OVERRUN = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [LEN_W-1:0]  frame_len_q, frame_len_d;
    logic              buf_we_q, buf_we_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [15:0]       buf_wdata_q, buf_wdata_d;
    logic              frame_valid_q, frame_valid_d;
    logic              busy_q, busy_d;
    logic [3:0]        err_flags_q, err_flags_d;
    logic [3:0]        err_set;
    logic [LEN_W-1:0]  cnt_inc;

    // A length byte is acceptable when it names 1..MAX_SAMPLES samples.
    function automatic logic hdr_len_ok(input logic [7:0] b);
        return (b != 8'd0) && (b <= MAX_LEN_B);
    endfunction

    assign cnt_inc = cnt_q + LEN_W'(1);

    // Next-state, buffer-write and error-event decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        frame_len_d   = frame_len_q;
        buf_we_d      = 1'b0;
        buf_addr_d    = buf_addr_q;
        buf_wdata_d   = buf_wdata_q;
        frame_valid_d = 1'b0;
        err_set       = 4'b0000;

        case (state_q)
            IDLE: begin
                // spi_active is deliberately not looked at here
                if (bus.byte_valid) begin
                    if (bus.byte_data == SYNC_BYTE) begin
                        state_d = HDR;
                    end else begin
                        err_set[ERR_SYNC] = 1'b1;
                    end
                end
            end

            HDR: begin
                // A dropped chip-select wins over a byte in the same cycle
                if (!bus.spi_active) begin
                    err_set[ERR_ABORT] = 1'b1;
                    state_d            = IDLE;
                end else if (bus.byte_valid) begin
                    if (hdr_len_ok(bus.byte_data)) begin
                        frame_len_d = LEN_W'(bus.byte_data);
                        cnt_d       = '0;
                        state_d     = DATA_HI;
                    end else begin
                        err_set[ERR_LEN] = 1'b1;
                        state_d          = IDLE;
                    end
                end
            end

            DATA_HI: begin
                if (!bus.spi_active) begin
                    err_set[ERR_ABORT] = 1'b1;
                    state_d            = IDLE;
                end else if (bus.byte_valid) begin
                    hi_d    = bus.byte_data;
                    state_d = DATA_LO;
                end
            end

            DATA_LO: begin
                if (!bus.spi_active) begin
                    err_set[ERR_ABORT] = 1'b1;
                    state_d            = IDLE;
                end else if (bus.byte_valid) begin
                    // The bound check keeps the address inside the frame even
                    // if the counter were ever corrupted; it cannot wrap.
                    if (cnt_q < frame_len_q) begin
                        buf_we_d    = 1'b1;
                        buf_addr_d  = cnt_q[ADDR_W-1:0];
                        buf_wdata_d = {hi_q, bus.byte_data};
                        cnt_d       = cnt_inc;
                    end
                    if (cnt_inc >= frame_len_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end

            DONE: begin
                // Bytes arriving while the frame is held are dropped, even
                // when the acknowledge lands in the same cycle.
                if (bus.byte_valid) begin
                    err_set[ERR_OVERRUN] = 1'b1;
                end
                if (bus.frame_ack) begin
                    state_d = IDLE;
                end else begin
                    frame_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear first, then OR in this cycle's events so a coincident event survives
        err_flags_d = (bus.err_clr ? 4'b0000 : err_flags_q) | err_set;
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= '0;
            frame_len_q   <= '0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_wdata_q   <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_flags_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            frame_len_q   <= frame_len_d;
            buf_we_q      <= buf_we_d;
            buf_addr_q    <= buf_addr_d;
            buf_wdata_q   <= buf_wdata_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            err_flags_q   <= err_flags_d;
        end
    end

    assign bus.buf_we      = buf_we_q;
    assign bus.buf_addr    = buf_addr_q;
    assign bus.buf_wdata   = buf_wdata_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.busy        = busy_q;
    assign bus.err_flags   = err_flags_q;

endmodule
